// File: rtl/cpu_trace_pkg.sv
//==============================================================================
// Module      : cpu_trace_pkg
// Description : Shared constants for the CPU trace capture block: FSM state
//               codes, entry width selection (TRACE_ALU_EN) and word indices.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_trace_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

`ifdef TRACE_ALU_EN
    localparam int WORDS_PER_ENTRY = 5;
`else
    localparam int WORDS_PER_ENTRY = 2;
`endif

    localparam logic [2:0] W_ADDR   = 3'd0;
    localparam logic [2:0] W_RESULT = 3'd1;
    localparam logic [2:0] W_ALU1   = 3'd2;
    localparam logic [2:0] W_ALU2   = 3'd3;
    localparam logic [2:0] W_ALUOUT = 3'd4;
    localparam logic [2:0] W_LAST   = 3'(WORDS_PER_ENTRY - 1);

endpackage

`default_nettype wire

// File: rtl/cpu_trace_capture_ram.sv
//==============================================================================
// Module      : trace_ram
// Description : DEPTH x WIDTH trace storage, synchronous write and
//               asynchronous read (maps to distributed RAM).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module trace_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/cpu_trace_capture.sv
//==============================================================================
// Module      : cpu_trace_capture
// Description : Records one entry per executed instruction (optionally from an
//               address trigger) and streams the buffer out as DW-bit words.
//               Define TRACE_ALU_EN to also capture the three ALU taps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   TrigEn,
    input  logic [DW-1:0]          TrigAddr,
    input  logic [DW-1:0]          Addr,
    input  logic [DW-1:0]          Result,
    input  logic [DW-1:0]          ALUin11,
    input  logic [DW-1:0]          ALUin22,
    input  logic [DW-1:0]          ALUoutt,
    output logic [DW-1:0]          OutData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic                   OutLast,
    output logic [$clog2(DEPTH):0] Count,
    output logic [7:0]             DropCnt,
    output logic [1:0]             State
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WORDS_PER_ENTRY * DW;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [1:0]    r_state;
    logic [DW-1:0] r_prev_addr;
    logic          r_first;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_word_idx;
    logic [7:0]    r_drop;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_qual, w_we, w_drop, w_first_n, w_adv, w_entry_end, w_nxt_last;
    logic [1:0]    w_next_state;
    logic [CW-1:0] w_cnt_inc;
    logic [AW-1:0] w_nxt_rd, w_rd_addr, w_last_ent;
    logic [2:0]    w_nxt_idx, w_sel_idx;
    logic [EW-1:0] w_wdata, w_rd_entry;
    logic [DW-1:0] w_rd_word;

    assign w_qual    = (Addr != r_prev_addr) || r_first;
    assign w_cnt_inc = r_count + {{(CW-1){1'b0}}, w_we};

    always_comb begin
        w_we         = 1'b0;
        w_drop       = 1'b0;
        w_first_n    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // Entering capture directly stores the current sample unconditionally
                if (Enable && TrigEn) begin
                    w_next_state = ARMED;
                    w_first_n    = 1'b1;
                end else if (Enable) begin
                    w_next_state = CAPTURE;
                    w_we         = 1'b1;
                end
            end
            ARMED: begin
                if (!Enable) begin
                    w_next_state = IDLE;
                end else if (w_qual && (Addr == TrigAddr)) begin
                    w_we         = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_qual) begin
                    w_we   = (r_count < c_depth);
                    w_drop = (r_count >= c_depth);
                end
                if (!Enable || (w_cnt_inc == c_depth)) begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_drop = w_qual;
                if ((r_count == '0) || (r_out_valid && OutReady && r_out_last)) begin
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_wdata = '0;
        w_wdata[W_ADDR*DW +: DW]   = Addr;
        w_wdata[W_RESULT*DW +: DW] = Result;
`ifdef TRACE_ALU_EN
        w_wdata[W_ALU1*DW +: DW]   = ALUin11;
        w_wdata[W_ALU2*DW +: DW]   = ALUin22;
        w_wdata[W_ALUOUT*DW +: DW] = ALUoutt;
`endif
    end

`ifndef TRACE_ALU_EN
    logic w_unused_alu;
    assign w_unused_alu = ^{ALUin11, ALUin22, ALUoutt, W_ALU1, W_ALU2, W_ALUOUT};
`endif

    // Readout address/index look one word ahead so the next word is registered on accept
    assign w_adv       = (r_state == DRAIN) && r_out_valid && OutReady;
    assign w_entry_end = (r_word_idx == W_LAST);
    assign w_nxt_idx   = w_entry_end ? W_ADDR : (r_word_idx + 3'd1);
    assign w_nxt_rd    = w_entry_end ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_rd_addr   = w_adv ? w_nxt_rd : r_rd_ptr;
    assign w_sel_idx   = w_adv ? w_nxt_idx : W_ADDR;
    assign w_last_ent  = AW'(r_count - 1'b1);
    assign w_nxt_last  = (w_nxt_rd == w_last_ent) && (w_nxt_idx == W_LAST);

    always_comb begin
        w_rd_word = w_rd_entry[DW-1:0];
        for (int k = 0; k < WORDS_PER_ENTRY; k++) begin
            if (w_sel_idx == 3'(k)) begin
                w_rd_word = w_rd_entry[k*DW +: DW];
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (Clock),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_prev_addr <= '0;
            r_first     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_word_idx  <= W_ADDR;
            r_drop      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_prev_addr <= Addr;
            r_first     <= w_first_n;
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= w_cnt_inc;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if ((r_state != DRAIN) && (w_next_state == DRAIN)) begin
                r_word_idx <= W_ADDR;
                if (w_cnt_inc != '0) begin
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    // An entry written on this same edge is not yet readable from the RAM
                    r_out_data  <= (r_count == '0) ? Addr : w_rd_word;
                end
            end else if (w_adv) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_count     <= '0;
                    r_wr_ptr    <= '0;
                    r_rd_ptr    <= '0;
                    r_word_idx  <= W_ADDR;
                end else begin
                    r_word_idx <= w_nxt_idx;
                    r_rd_ptr   <= w_nxt_rd;
                    r_out_data <= w_rd_word;
                    r_out_last <= w_nxt_last;
                end
            end
        end
    end

    assign OutData  = r_out_data;
    assign OutValid = r_out_valid;
    assign OutLast  = r_out_last;
    assign Count    = r_count;
    assign DropCnt  = r_drop;
    assign State    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_trace_capture.sv
//==============================================================================
// Module      : tb_cpu_trace_capture
// Description : Self-checking bench for cpu_trace_capture (default build,
//               DEPTH=16, DW=32) against a queue-based behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_trace_capture;

    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic          Clock, Reset, Enable, TrigEn, OutReady;
    logic [DW-1:0] TrigAddr, Addr, Result, alu1, alu2, alu3;
    logic [DW-1:0] OutData;
    logic          OutValid, OutLast;
    logic [4:0]    Count;
    logic [7:0]    DropCnt;
    logic [1:0]    State;

    cpu_trace_capture #(.DEPTH(DEPTH), .DW(DW)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .TrigEn(TrigEn),
        .TrigAddr(TrigAddr), .Addr(Addr), .Result(Result),
        .ALUin11(alu1), .ALUin22(alu2), .ALUoutt(alu3),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .OutLast(OutLast), .Count(Count), .DropCnt(DropCnt), .State(State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int errors = 0;
    int checks = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: entries kept as queues, drain output as a flat word list
    int          m_state, m_count, m_drop;
    logic [31:0] m_prev;
    bit          m_first, q, nf;
    logic [31:0] m_ea[$], m_er[$], m_words[$];

    task automatic m_store();
        m_ea.push_back(Addr);
        m_er.push_back(Result);
        m_count++;
    endtask

    task automatic m_bump();
        if (m_drop < 255) m_drop++;
    endtask

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_state = 0; m_count = 0; m_drop = 0; m_prev = 0; m_first = 0;
            m_ea.delete(); m_er.delete(); m_words.delete();
        end else begin
            q  = (Addr != m_prev) || m_first;
            nf = 0;
            case (m_state)
                0: if (Enable) begin
                       if (TrigEn) begin m_state = 1; nf = 1; end
                       else begin m_store(); m_state = 2; end
                   end
                1: if (!Enable) m_state = 0;
                   else if (q && Addr == TrigAddr) begin m_store(); m_state = 2; end
                2: begin
                       if (q) begin
                           if (m_count < DEPTH) m_store(); else m_bump();
                       end
                       if (!Enable || m_count == DEPTH) begin
                           m_state = 3;
                           m_words.delete();
                           foreach (m_ea[i]) begin
                               m_words.push_back(m_ea[i]);
                               m_words.push_back(m_er[i]);
                           end
                       end
                   end
                default: begin
                       if (q) m_bump();
                       if (m_count == 0) m_state = 0;
                       else if (OutReady) begin
                           void'(m_words.pop_front());
                           if (m_words.size() == 0) begin
                               m_count = 0; m_ea.delete(); m_er.delete(); m_state = 0;
                           end
                       end
                   end
            endcase
            m_first = nf;
            m_prev  = Addr;
        end
    end

    always @(negedge Clock) begin
        if (chk_on) begin
            check("state", {30'd0, State}, m_state);
            check("count", {27'd0, Count}, m_count);
            check("dropcnt", {24'd0, DropCnt}, m_drop);
            check("outvalid", {31'd0, OutValid}, (m_state == 3 && m_words.size() != 0) ? 1 : 0);
            if (m_state == 3 && m_words.size() != 0) begin
                check("outdata", OutData, m_words[0]);
                check("outlast", {31'd0, OutLast}, (m_words.size() == 1) ? 1 : 0);
            end else begin
                check("outlast_idle", {31'd0, OutLast}, 0);
            end
        end
    end

    logic [31:0] got [64];
    logic        gl  [64];
    int          n_got;
    logic [31:0] expa [6] = '{32'h0, 32'h1, 32'h4, 32'h2, 32'h8, 32'h3};

    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] r);
        Enable = en; Addr = a; Result = r;
        @(posedge Clock); #1;
    endtask

    // pat gives OutReady for the first four drain cycles (MSB first), then 1
    task automatic drain(input logic [3:0] pat);
        logic [31:0] pd;
        bit stalled, done;
        Enable = 1'b0; n_got = 0; stalled = 0; done = 0; pd = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (State == 2'd0 && !OutValid) begin done = 1; break; end
            if (stalled && OutValid) check("stall_hold", OutData, pd);
            OutReady = (i < 4) ? pat[3-i] : 1'b1;
            if (OutValid && OutReady && n_got < 64) begin
                got[n_got] = OutData; gl[n_got] = OutLast; n_got++;
            end
            stalled = OutValid && !OutReady;
            pd = OutData;
        end
        if (!done) check("drain_done", 0, 1);
        OutReady = 1'b0;
        @(posedge Clock); #1;
    endtask

    initial begin
        Reset = 1'b1; Enable = 0; TrigEn = 0; TrigAddr = 0; Addr = 0; Result = 0;
        OutReady = 0; alu1 = 32'h11; alu2 = 32'h22; alu3 = 32'h33;
        @(posedge Clock); #1;
        chk_on = 1'b1;
        @(negedge Clock);
        check("rst_outdata", OutData, 0);
        check("rst_outvalid", {31'd0, OutValid}, 0);
        check("rst_count", {27'd0, Count}, 0);
        check("rst_state", {30'd0, State}, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Immediate capture of three instructions
        step(1, 32'h0, 32'h1); step(1, 32'h4, 32'h2); step(1, 32'h8, 32'h3); step(0, 32'h8, 32'h3);
        check("a_count", {27'd0, Count}, 3);
        check("a_state", {30'd0, State}, 3);
        drain(4'b1111);
        check("a_nwords", n_got, 6);
        for (int k = 0; k < 6; k++) begin
            check("a_word", got[k], expa[k]);
            check("a_last", {31'd0, gl[k]}, (k == 5) ? 1 : 0);
        end
        check("a_idle", {30'd0, State}, 0);

        // Address trigger at 0x10
        TrigEn = 1; TrigAddr = 32'h10;
        step(1, 32'h0, 32'hA0); step(1, 32'h8, 32'hA1); step(1, 32'h10, 32'hA2);
        step(1, 32'h14, 32'hA3); step(0, 32'h14, 32'hA3);
        check("b_count", {27'd0, Count}, 2);
        drain(4'b1111);
        check("b_nwords", n_got, 4);
        check("b_w0", got[0], 32'h10);
        check("b_w1", got[1], 32'hA2);
        check("b_w2", got[2], 32'h14);
        check("b_w3", got[3], 32'hA3);

        // Address held for five cycles gives one entry
        TrigEn = 0;
        for (int k = 0; k < 5; k++) step(1, 32'h20, 32'h55);
        step(0, 32'h20, 32'h55);
        check("c_count", {27'd0, Count}, 1);
        drain(4'b1111);
        check("c_nwords", n_got, 2);
        check("c_w0", got[0], 32'h20);
        check("c_w1", got[1], 32'h55);

        // Readout with OutReady 1,0,0,1
        step(1, 32'h30, 32'h31); step(1, 32'h34, 32'h35); step(0, 32'h34, 32'h35);
        drain(4'b1001);
        check("d_nwords", n_got, 4);
        check("d_w0", got[0], 32'h30);
        check("d_w1", got[1], 32'h31);
        check("d_w2", got[2], 32'h34);
        check("d_w3", got[3], 32'h35);

        // Overflow: 20 distinct samples into 16 entries, then drop saturation
        for (int k = 0; k < 20; k++) step(1, 32'h100 + 32'(4*k), 32'(k));
        check("e_count", {27'd0, Count}, 16);
        check("e_state", {30'd0, State}, 3);
        check("e_drop4", {24'd0, DropCnt}, 4);
        for (int k = 0; k < 260; k++) step(1, 32'h1000 + 32'(4*k), 32'hEE);
        check("e_drop_sat", {24'd0, DropCnt}, 255);
        drain(4'b1111);
        check("e_nwords", n_got, 32);
        check("e_first", got[0], 32'h100);
        check("e_lastw", got[31], 32'd15);
        check("e_lastflag", {31'd0, gl[31]}, 1);

        // Reset in the middle of a drain
        step(1, 32'h40, 32'h1); step(1, 32'h44, 32'h2); step(0, 32'h44, 32'h2);
        @(negedge Clock);
        check("f_valid_pre", {31'd0, OutValid}, 1);
        #2 Reset = 1'b1;
        @(posedge Clock); #1;
        @(negedge Clock);
        check("f_valid", {31'd0, OutValid}, 0);
        check("f_count", {27'd0, Count}, 0);
        check("f_state", {30'd0, State}, 0);
        check("f_drop", {24'd0, DropCnt}, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Arm then drop Enable before the trigger
        TrigEn = 1; TrigAddr = 32'h99;
        step(1, 32'h50, 32'h0); step(1, 32'h54, 32'h0); step(0, 32'h58, 32'h0);
        check("g_state", {30'd0, State}, 0);
        check("g_count", {27'd0, Count}, 0);
        repeat (3) step(0, 32'h58, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
- Passive consumer of the CPU core's debug outputs (Addr, Result and the ALU operand/result taps).
- Records one entry per executed instruction into an on-chip trace buffer, optionally starting on an address trigger.
- Streams the buffer out as 32-bit words over a valid/ready interface to a host-side reader (UART bridge or bench monitor).
- Sits beside CPU in the FPGA top level, sharing Clock and Reset.

Parameters:
- DEPTH, 16, number of trace entries; power of two, 2..256.
- DW, 32, width of every captured field and of OutData.

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Enable  in  1  arm/run capture; falling edge ends capture.
- TrigEn  in  1  1 = wait for Addr==TrigAddr before storing; 0 = store immediately.
- TrigAddr  in  DW  trigger PC value.
- Addr  in  DW  CPU instruction address.
- Result  in  DW  CPU writeback result.
- ALUin11, ALUin22, ALUoutt  in  DW each  ALU taps; used only with TRACE_ALU_EN.
- OutData  out  DW  readout word.
- OutValid  out  1  OutData valid.
- OutReady  in  1  reader accepts word.
- OutLast  out  1  final word of the final entry.
- Count  out  $clog2(DEPTH)+1  entries stored.
- DropCnt  out  8  qualified samples not stored; saturates at 255.
- State  out  2  FSM state code.

Behaviour:
- Reset values: OutData=0, OutValid=0, OutLast=0, Count=0, DropCnt=0, State=IDLE(0), previous-Addr register=0, write/read pointers=0, word index=0.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3.
- A sample is qualified when Addr differs from the registered previous Addr, or it is the first cycle in ARMED/CAPTURE after leaving IDLE.
- IDLE:
  - Enable=1 and TrigEn=1 goes to ARMED.
  - Enable=1 and TrigEn=0 goes to CAPTURE, and the qualified sample on that edge is stored.
- ARMED:
  - A qualified sample with Addr==TrigAddr is stored as entry 0 on that edge, then the FSM goes to CAPTURE.
  - Enable=0 returns to IDLE without output.
- CAPTURE:
  - Every qualified sample is written at wr_ptr; Count increments one cycle later.
  - When Count reaches DEPTH, or Enable falls, the FSM goes to DRAIN.
  - A sample on the same edge Enable falls is still stored if space remains.
- Full: qualified samples arriving while full, or during DRAIN, increment DropCnt (saturating) and are not stored.
- DRAIN:
  - Entering DRAIN with Count=0 returns to IDLE on the next edge; OutValid stays 0.
  - Otherwise OutValid=1 from the first DRAIN cycle.
  - Word order per entry: Addr, Result (plus ALUin11, ALUin22, ALUoutt with TRACE_ALU_EN). Entries are emitted oldest first.
  - OutData, OutValid and OutLast are registered and held stable while OutValid && !OutReady.
  - A word advances on an edge with OutValid && OutReady; a new word is presented the next cycle, so throughput is 1 word/cycle.
  - OutLast=1 only with the last word of entry Count-1.
  - Acceptance of the last word clears Count and the pointers, deasserts OutValid, and returns to IDLE.
  - Enable is ignored during DRAIN.
- Asynchronous Reset at any time aborts capture or drain and forces the reset values; a partially read entry is discarded.
- Pointers are $clog2(DEPTH) bits and wrap naturally; Count is one bit wider so it can distinguish full from empty.

Optional Feature:
- Macro: TRACE_ALU_EN.
- Defined: entry is 5×DW bits, 5 words per entry; ALU taps are sampled on the same edge as Addr.
- Undefined: entry is 2×DW bits, 2 words per entry; ALU ports are unconnected inputs and no storage is inferred for them.

Decomposition:
- Package cpu_trace_pkg holds:
  - state encoding constants (IDLE, ARMED, CAPTURE, DRAIN);
  - WORDS_PER_ENTRY (2 or 5, selected by TRACE_ALU_EN);
  - word-index constants (W_ADDR=0, W_RESULT=1, W_ALU1=2, W_ALU2=3, W_ALUOUT=4).
- Sub-module trace_ram: DEPTH × (WORDS_PER_ENTRY·DW), synchronous write, asynchronous read (distributed RAM), one write port and one read port.

Test Plan:
- Reset=1 mid-DRAIN with OutValid=1 → next cycle OutValid=0, Count=0, State=0, DropCnt=0.
- TrigEn=0, Enable=1, Addr steps 0,4,8 (Result 1,2,3), then Enable=0 → Count=3; with OutReady=1 stream 0,1,4,2,8,3; OutLast on the word 3 only; State returns to 0.
- TrigEn=1, TrigAddr=0x10, Addr steps 0x0,0x8,0x10,0x14 → entries (0x10,…),(0x14,…) only; Count=2.
- DEPTH=16, 20 distinct Addr values with Enable=1 → Count=16, State=DRAIN, DropCnt=4; DropCnt stops at 255 under continued stimulus.
- Addr held at 0x20 for 5 cycles in CAPTURE → exactly one entry stored.
- OutReady toggled 1,0,0,1 during DRAIN → OutData unchanged across the stalled cycles; no word duplicated or skipped.
